// File: rtl/alu_word_sequencer.sv
// Multi-cycle word ALU sequencer: drives an external 8-bit ALU slice one byte per
// cycle (LSB first), chaining carry, and returns the assembled word and flags.
module alu_word_sequencer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic                  cmd_cin,
  input  logic [8*NBYTES-1:0]   cmd_a,
  input  logic [8*NBYTES-1:0]   cmd_b,
  output logic [2:0]            alu_op,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cin,
  input  logic [7:0]            alu_sum,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_result,
  output logic                  rsp_cout,
  output logic                  rsp_zero,
  output logic                  rsp_ovf
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_RSUB = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      byte_a, byte_b;
  logic            arith;
  logic            sa, sb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_ISSUE;
      S_ISSUE: if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand byte select and signed-overflow addend signs for the current byte.
  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_q == IDXW'(i)) begin
        byte_a = a_q[i*8 +: 8];
        byte_b = b_q[i*8 +: 8];
      end
    end
    arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_RSUB);
    sa = 1'b0;
    sb = 1'b0;
    unique case (op_q)
      OP_ADD:  begin sa = byte_a[7]; sb = byte_b[7];  end
      OP_SUB:  begin sa = byte_a[7]; sb = ~byte_b[7]; end
      OP_RSUB: begin sa = byte_b[7]; sb = ~byte_a[7]; end
      default: begin sa = 1'b0;      sb = 1'b0;       end
    endcase
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          a_d      = cmd_a;
          b_d      = cmd_b;
          carry_d  = (cmd_op == OP_ADD) ? cmd_cin
                                        : ((cmd_op == OP_SUB) || (cmd_op == OP_RSUB));
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      S_ISSUE: begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (idx_q == IDXW'(i)) result_d[i*8 +: 8] = alu_sum;
        end
        carry_d = alu_cout;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          cout_d = arith & alu_cout;
          ovf_d  = arith && (sa == sb) && (alu_sum[7] != sa);
          zero_d = (result_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    rsp_valid  = (state_q == S_DONE);
    rsp_result = result_q;
    rsp_cout   = cout_q;
    rsp_zero   = zero_q;
    rsp_ovf    = ovf_q;
    alu_op     = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    if (state_q == S_ISSUE) begin
      alu_op  = op_q;
      alu_a   = byte_a;
      alu_b   = byte_b;
      alu_cin = carry_q;
    end
  end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Scoreboard bench for alu_word_sequencer with a behavioural 8-bit ALU slice.
module tb_alu_word_sequencer;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic         cmd_cin;
  logic [W-1:0] cmd_a, cmd_b;
  logic [2:0]   alu_op;
  logic [7:0]   alu_a, alu_b;
  logic         alu_cin;
  logic [7:0]   alu_sum;
  logic         alu_cout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_cout, rsp_zero, rsp_ovf;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  alu_word_sequencer #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_sum(alu_sum), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  // External ALU slice
  always_comb begin
    logic [8:0] s;
    s = '0;
    case (alu_op)
      3'd0: s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      3'd1: s = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
      3'd2: s = {1'b0, alu_b} + {1'b0, ~alu_a} + {8'd0, alu_cin};
      3'd3: s = {1'b0, alu_a | alu_b};
      3'd4: s = {1'b0, alu_a & alu_b};
      3'd5: s = {1'b0, ~alu_a & alu_b};
      3'd6: s = {1'b0, alu_a ^ alu_b};
      default: s = {1'b0, ~(alu_a ^ alu_b)};
    endcase
    alu_sum  = s[7:0];
    alu_cout = s[8];
  end

  function automatic exp_t model(input logic [2:0] op, input logic cin,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    logic sa, sb;
    s = '0; sa = 1'b0; sb = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; sa = a[W-1]; sb = b[W-1]; end
      3'd1: begin s = {1'b0, a} - {1'b0, b} + {1'b1, {W{1'b0}}}; sa = a[W-1]; sb = ~b[W-1]; end
      3'd2: begin s = {1'b0, b} - {1'b0, a} + {1'b1, {W{1'b0}}}; sa = b[W-1]; sb = ~a[W-1]; end
      3'd3: s = {1'b0, a | b};
      3'd4: s = {1'b0, a & b};
      3'd5: s = {1'b0, ~a & b};
      3'd6: s = {1'b0, a ^ b};
      default: s = {1'b0, ~(a ^ b)};
    endcase
    e.res  = s[W-1:0];
    e.cout = (op <= 3'd2) ? s[W] : 1'b0;
    e.ovf  = (op <= 3'd2) && (sa == sb) && (s[W-1] != sa);
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first issue cycle.
  task automatic send(input logic [2:0] op, input logic cin,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_cin = cin; cmd_a = a; cmd_b = b;
    exp_q.push_back(model(op, cin, a, b));
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = '0; cmd_cin = 1'b0; cmd_a = '0; cmd_b = '0;
  endtask

  // Waits for rsp_valid, compares against the scoreboard, handshakes (rsp_ready high).
  task automatic recv(input string tag, input int start_lat);
    int lat = start_lat;
    exp_t e;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    check({tag, "_latency"}, 64'(lat), 64'(NBYTES + 1));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 64'(rsp_result), 64'(e.res));
      check({tag, "_cout"},   64'(rsp_cout),   64'(e.cout));
      check({tag, "_zero"},   64'(rsp_zero),   64'(e.zero));
      check({tag, "_ovf"},    64'(rsp_ovf),    64'(e.ovf));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] lop;
    int quiet;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_cin = 1'b0;
    cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_flags", {60'd0, rsp_cout, rsp_zero, rsp_ovf, 1'b0}, 64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    check("rst_alu", {44'd0, alu_op, alu_a, alu_b, alu_cin}, 64'd0);

    // add with carry ripple into byte 1
    send(3'd0, 1'b0, 32'h0000_00FF, 32'h0000_0001);
    check("add_b0_alu", {44'd0, alu_op, alu_a, alu_b, alu_cin}, {44'd0, 3'd0, 8'hFF, 8'h01, 1'b0});
    check("add_cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    check("add_b1_cin", {63'd0, alu_cin}, 64'd1);
    recv("add", 2);

    send(3'd1, 1'b0, 32'h0000_0000, 32'h0000_0001); recv("sub_wrap", 1);
    send(3'd1, 1'b1, 32'h8000_0000, 32'h0000_0001); recv("sub_ovf", 1);
    send(3'd2, 1'b0, 32'h1234_5678, 32'h1234_5678); recv("rsub_zero", 1);
    send(3'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001); recv("add_ovf", 1);
    send(3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000); recv("add_cin", 1);

    for (int i = 3; i < 8; i++) begin
      lop = 3'(i);
      send(lop, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00);
      recv($sformatf("logic%0d", i), 1);
    end

    for (int i = 0; i < 6; i++) begin
      send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      recv($sformatf("rand%0d", i), 1);
    end

    // backpressure
    rsp_ready = 1'b0;
    send(3'd6, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (NBYTES) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {28'd0, rsp_result, rsp_valid, cmd_ready, rsp_cout, rsp_ovf},
            {28'd0, 32'hDEAD_BEEF ^ 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
    end
    recv("bp", NBYTES + 1);
    check("bp_idle_ready", {63'd0, cmd_ready}, 64'd1);
    send(3'd0, 1'b0, 32'h0000_1234, 32'h0000_4321); recv("b2b", 1);

    // reset mid-ISSUE during byte 2
    send(3'd0, 1'b0, 32'h0101_0101, 32'h0202_0202);
    repeat (2) @(negedge clk);
    check("mid_b2_idx", 64'(alu_a), 64'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("mid_rst_ready", {63'd0, cmd_ready}, 64'd1);
    check("mid_rst_rsp", {29'd0, rsp_result, rsp_valid, rsp_cout, rsp_zero}, 64'd0);
    check("mid_rst_alu", {44'd0, alu_op, alu_a, alu_b, alu_cin}, 64'd0);
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) quiet++;
      @(negedge clk);
    end
    check("mid_rst_no_rsp", 64'(quiet), 64'd0);
    send(3'd0, 1'b0, 32'd1, 32'd1); recv("post_rst_add", 1);

    // reset beats a simultaneous command
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 32'd5; cmd_b = 32'd6;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_vs_cmd", {62'd0, cmd_ready, rsp_valid}, 64'd2);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
